wrr_pop_scheduler: RTL and testbench

//  Weighted round-robin pop scheduler for the four transaction-layer virtual-channel FIFOs.

---
 rtl/wrr_pop_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_wrr_pop_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin pop scheduler for four VC FIFOs. Each eligible queue is
// served for up to its weight of consecutive pops. All pops stall while any
// downstream almost_full flag is set.
module wrr_pop_scheduler #(
  parameter int          CNT_W  = 3,
  parameter int unsigned W0_DEF = 4,
  parameter int unsigned W1_DEF = 3,
  parameter int unsigned W2_DEF = 2,
  parameter int unsigned W3_DEF = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       state,
  input  logic [CNT_W-1:0] weight0,
  input  logic [CNT_W-1:0] weight1,
  input  logic [CNT_W-1:0] weight2,
  input  logic [CNT_W-1:0] weight3,
  input  logic             empty0,
  input  logic             empty1,
  input  logic             empty2,
  input  logic             empty3,
  input  logic             almost_full0,
  input  logic             almost_full1,
  input  logic             almost_full2,
  input  logic             almost_full3,
  output logic             pop0,
  output logic             pop1,
  output logic             pop2,
  output logic             pop3,
  output logic [1:0]       active_q,
  output logic             busy,
  output logic [7:0]       served_total
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    STALL = 2'd2
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] credit_q, credit_d;
  logic [7:0]       served_q, served_d;
  logic [CNT_W-1:0] wreg_q [4];

  logic [3:0] empty_v;
  logic [3:0] elig_v;
  logic [3:0] pop_v;
  logic       any_af;
  logic       link_rst;
  logic [2:0] idle_srch;
  logic [2:0] serve_srch;

  // First eligible queue starting at 'start' and wrapping; returns {hit, index}.
  function automatic logic [2:0] find_next(input logic [3:0] elig, input logic [1:0] start);
    logic       found;
    logic [1:0] idx;
    logic [1:0] res;
    found = 1'b0;
    res   = start;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        res   = idx;
      end
    end
    return {found, res};
  endfunction

  assign empty_v  = {empty3, empty2, empty1, empty0};
  assign any_af   = almost_full0 | almost_full1 | almost_full2 | almost_full3;
  assign link_rst = (state == 4'b0001);

  // Eligibility, search results and the pop strobes.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      elig_v[i] = ~empty_v[i] & (wreg_q[i] != '0);
    end
    idle_srch  = find_next(elig_v, ptr_q);
    serve_srch = find_next(elig_v, ptr_q + 2'd1);
    pop_v      = 4'b0000;
    if ((fsm_q == SERVE) && !empty_v[ptr_q] && (credit_q != '0) && !any_af && !link_rst) begin
      pop_v[ptr_q] = 1'b1;
    end else begin
      pop_v = 4'b0000;
    end
  end

  // Next-state logic; a credit of 0 in SERVE is treated like an exhausted grant.
  always_comb begin
    fsm_d    = fsm_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    served_d = served_q + {7'd0, |pop_v};
    if (link_rst) begin
      fsm_d    = IDLE;
      ptr_d    = 2'd0;
      credit_d = '0;
      served_d = 8'd0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (idle_srch[2]) begin
            fsm_d    = SERVE;
            ptr_d    = idle_srch[1:0];
            credit_d = wreg_q[idle_srch[1:0]];
          end else begin
            fsm_d = IDLE;
          end
        end
        SERVE: begin
          if (any_af) begin
            fsm_d = STALL;
          end else if (empty_v[ptr_q] || (credit_q <= CNT_W'(1))) begin
            if (serve_srch[2]) begin
              ptr_d    = serve_srch[1:0];
              credit_d = wreg_q[serve_srch[1:0]];
            end else begin
              fsm_d = IDLE;
            end
          end else begin
            credit_d = credit_q - CNT_W'(1);
          end
        end
        STALL: begin
          if (!any_af) begin
            fsm_d = SERVE;
          end else begin
            fsm_d = STALL;
          end
        end
        default: begin
          fsm_d = IDLE;
        end
      endcase
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q    <= IDLE;
      ptr_q    <= 2'd0;
      credit_q <= '0;
      served_q <= 8'd0;
    end else begin
      fsm_q    <= fsm_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      served_q <= served_d;
    end
  end

  // Weight registers load only while the link is in RESET.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wreg_q[0] <= CNT_W'(W0_DEF);
      wreg_q[1] <= CNT_W'(W1_DEF);
      wreg_q[2] <= CNT_W'(W2_DEF);
      wreg_q[3] <= CNT_W'(W3_DEF);
    end else if (link_rst) begin
      wreg_q[0] <= weight0;
      wreg_q[1] <= weight1;
      wreg_q[2] <= weight2;
      wreg_q[3] <= weight3;
    end else begin
      for (int i = 0; i < 4; i++) begin
        wreg_q[i] <= wreg_q[i];
      end
    end
  end

  assign pop0         = pop_v[0];
  assign pop1         = pop_v[1];
  assign pop2         = pop_v[2];
  assign pop3         = pop_v[3];
  assign active_q     = ptr_q;
  assign busy         = (fsm_q != IDLE);
  assign served_total = served_q;

endmodule

// File: tb/tb_wrr_pop_scheduler.sv
// Directed bench for wrr_pop_scheduler: FIFO fill levels are modelled in the
// bench and every pop pattern below is worked out by hand.
module tb_wrr_pop_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] state;
  logic [2:0] weight0, weight1, weight2, weight3;
  logic       almost_full0, almost_full1, almost_full2, almost_full3;
  logic       pop0, pop1, pop2, pop3;
  logic [1:0] active_q;
  logic       busy;
  logic [7:0] served_total;
  int         cnt [4];
  int         vectors;
  int         miscompares;

  wire        empty0 = (cnt[0] == 0);
  wire        empty1 = (cnt[1] == 0);
  wire        empty2 = (cnt[2] == 0);
  wire        empty3 = (cnt[3] == 0);
  wire [3:0]  pop_v  = {pop3, pop2, pop1, pop0};

  int seq_a [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
  int seq_w [7]  = '{0, 0, 0, 0, 2, 2, 3};
  int seq_e [9]  = '{0, 0, -1, 1, 1, 1, 2, 2, 3};
  int seq_s [6]  = '{1, 1, 1, 2, 2, 3};

  wrr_pop_scheduler dut (
    .clk(clk), .reset(reset), .state(state),
    .weight0(weight0), .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .empty0(empty0), .empty1(empty1), .empty2(empty2), .empty3(empty3),
    .almost_full0(almost_full0), .almost_full1(almost_full1),
    .almost_full2(almost_full2), .almost_full3(almost_full3),
    .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
    .active_q(active_q), .busy(busy), .served_total(served_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input int q);
    logic [3:0] one;
    one = 4'b0001;
    return (q < 0) ? 4'b0000 : (one << q);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; the modelled FIFOs lose an entry for every observed pop.
  task automatic tick();
    logic [3:0] p;
    p = pop_v;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (p[i] && cnt[i] > 0) cnt[i]--;
    end
  endtask

  task automatic cyc_expect(input string tag, input int q);
    #2;
    chk(tag, {28'd0, pop_v}, {28'd0, oh(q)});
    tick();
  endtask

  task automatic fill_all(input int c0);
    cnt[0] = c0;
    cnt[1] = 1000;
    cnt[2] = 1000;
    cnt[3] = 1000;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    state = 4'b0010;
    weight0 = 3'd4; weight1 = 3'd3; weight2 = 3'd2; weight3 = 3'd1;
    almost_full0 = 1'b0; almost_full1 = 1'b0; almost_full2 = 1'b0; almost_full3 = 1'b0;
    fill_all(1000);

    // Test 1: reset state and first pop one cycle after release.
    #3;
    chk("rst_pops", {28'd0, pop_v}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_active", {30'd0, active_q}, 32'd0);
    chk("rst_served", {24'd0, served_total}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc_expect("rel_nopop", -1);
    chk("rel_busy", {31'd0, busy}, 32'd1);
    cyc_expect("rel_pop0", 0);

    // Test 2: load 4,3,2,1 and check the repeating schedule.
    state = 4'b0001;
    cyc_expect("load_nopop", -1);
    state = 4'b0010;
    chk("load_served", {24'd0, served_total}, 32'd0);
    chk("load_busy", {31'd0, busy}, 32'd0);
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 10; k++) cyc_expect("wrr_seq", seq_a[k]);
    end
    chk("wrr_served", {24'd0, served_total}, 32'd20);

    // Test 3: almost_full during the second pop1.
    for (int k = 0; k < 5; k++) cyc_expect("af_pre", seq_a[k]);
    almost_full2 = 1'b1;
    for (int k = 0; k < 3; k++) cyc_expect("af_stall", -1);
    chk("af_busy", {31'd0, busy}, 32'd1);
    almost_full2 = 1'b0;
    cyc_expect("af_bubble", -1);
    cyc_expect("af_post", 1);
    cyc_expect("af_post", 1);
    cyc_expect("af_post", 2);
    cyc_expect("af_post", 2);
    cyc_expect("af_post", 3);

    // Test 4: weight1 = 0 removes queue 1 from the rotation.
    state = 4'b0001;
    weight1 = 3'd0;
    fill_all(1000);
    cyc_expect("w0_load", -1);
    state = 4'b0010;
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 7; k++) cyc_expect("w0_seq", seq_w[k]);
    end

    // Test 5: queue 0 runs dry after 2 pops; served_total wraps at 256.
    state = 4'b0001;
    weight1 = 3'd3;
    fill_all(2);
    cyc_expect("dry_load", -1);
    state = 4'b0010;
    tick();
    for (int k = 0; k < 9; k++) cyc_expect("dry_seq", seq_e[k]);
    for (int k = 0; k < 247; k++) cyc_expect("dry_steady", seq_s[k % 6]);
    chk("served_255", {24'd0, served_total}, 32'd255);
    cyc_expect("dry_steady", seq_s[247 % 6]);
    chk("served_wrap", {24'd0, served_total}, 32'd0);

    // Test 6: link reset mid-burst on queue 1.
    state = 4'b0001;
    fill_all(1000);
    cyc_expect("mid_load", -1);
    state = 4'b0010;
    tick();
    for (int k = 0; k < 5; k++) cyc_expect("mid_pre", seq_a[k]);
    chk("mid_served", {24'd0, served_total}, 32'd5);
    state = 4'b0001;
    weight0 = 3'd1; weight1 = 3'd1; weight2 = 3'd1; weight3 = 3'd1;
    #2;
    chk("mid_active", {30'd0, active_q}, 32'd1);
    cyc_expect("mid_drop", -1);
    chk("mid_ptr", {30'd0, active_q}, 32'd0);
    chk("mid_clr", {24'd0, served_total}, 32'd0);
    chk("mid_idle", {31'd0, busy}, 32'd0);
    state = 4'b0010;
    tick();
    for (int k = 0; k < 6; k++) cyc_expect("new_w", k % 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
